// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM CPU-side port arbiter.
// Requester indices, bus widths, the registered command and the read-return tag.
package sdram_arb_pkg;

  localparam logic [1:0] REQ_VIDEO = 2'd0;
  localparam logic [1:0] REQ_CPU   = 2'd1;
  localparam logic [1:0] REQ_DMA   = 2'd2;

  localparam int SDRAM_AW = 25;
  localparam int SDRAM_DW = 16;

  typedef struct packed {
    logic [SDRAM_AW-1:0] addr;
    logic [SDRAM_DW-1:0] din;
    logic [1:0]          ds;
    logic                we;
  } sdram_cmd_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } ret_slot_t;

  function automatic logic [1:0] onehot_idx(input logic [2:0] v);
    if (v[2])      return REQ_DMA;
    else if (v[1]) return REQ_CPU;
    else           return REQ_VIDEO;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: video first unless its burst cap is reached
// with a CPU/DMA request waiting; CPU and DMA share by a round-robin pointer.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int VID_BURST_MAX = 8,
  parameter int CW            = 4
) (
  input  logic [2:0]    req,
  input  logic [1:0]    rr_ptr,
  input  logic [CW-1:0] vid_cnt,
  input  logic          idle,
  output logic [2:0]    gnt
);

  logic       low_any;
  logic       force_low;
  logic [1:0] low_idx;

  always_comb begin
    gnt       = '0;
    low_any   = req[REQ_CPU] | req[REQ_DMA];
    force_low = (vid_cnt == CW'(VID_BURST_MAX)) && low_any;
    if (req[REQ_CPU] && req[REQ_DMA]) low_idx = rr_ptr;
    else if (req[REQ_CPU])            low_idx = REQ_CPU;
    else                              low_idx = REQ_DMA;

    if (!idle) begin
      if (req[REQ_VIDEO] && !force_low) gnt[REQ_VIDEO] = 1'b1;
      else if (low_any)                 gnt[low_idx]   = 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter for the single SDRAM CPU-side port (video, 68k, DMA).
// Registers one command per grant and tags read returns two cycles later.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int VID_BURST_MAX  = 8,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic                              clk_sys,
  input  logic                              RESET,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                we,
  input  logic [NUM_REQ-1:0][SDRAM_AW-1:0]  addr,
  input  logic [NUM_REQ-1:0][SDRAM_DW-1:0]  din,
  input  logic [NUM_REQ-1:0][1:0]           ds,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [NUM_REQ-1:0]                rvalid,
  output logic [SDRAM_DW-1:0]               rdata,
  output logic [SDRAM_AW-1:0]               sdram_addr,
  output logic [SDRAM_DW-1:0]               sdram_din,
  output logic [1:0]                        sdram_ds,
  output logic                              sdram_we,
  output logic                              sdram_oe,
  input  logic [SDRAM_DW-1:0]               sdram_out
);

  localparam int CW = $clog2(VID_BURST_MAX + 1);
  localparam int RW = $clog2(REFRESH_PERIOD);

  logic [CW-1:0] vid_cnt;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    rr_ptr;
  logic          ref_slot;
  logic          gnt_any;
  logic [1:0]    gnt_idx;
  sdram_cmd_t    cmd_q;
  logic          cmd_vld;
  ret_slot_t     ret_pipe [2:1];

  // The refresh slot is the last count of the period; reset also blocks grants.
  assign ref_slot = (ref_cnt == RW'(REFRESH_PERIOD - 1));
  assign gnt_any  = |gnt;
  assign gnt_idx  = onehot_idx(gnt);

  sdram_arb_pick #(
    .VID_BURST_MAX (VID_BURST_MAX),
    .CW            (CW)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .vid_cnt (vid_cnt),
    .idle    (RESET | ref_slot),
    .gnt     (gnt)
  );

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      cmd_q       <= '0;
      cmd_vld     <= 1'b0;
      ret_pipe[1] <= '0;
      ret_pipe[2] <= '0;
      rr_ptr      <= REQ_CPU;
      vid_cnt     <= '0;
      ref_cnt     <= '0;
    end else begin
      ref_cnt <= ref_slot ? '0 : ref_cnt + 1'b1;

      cmd_vld <= gnt_any;
      if (gnt_any) begin
        cmd_q.addr <= addr[gnt_idx];
        cmd_q.din  <= din[gnt_idx];
        cmd_q.ds   <= ds[gnt_idx];
        cmd_q.we   <= we[gnt_idx];
      end

      ret_pipe[1].valid <= gnt_any & ~we[gnt_idx];
      ret_pipe[1].idx   <= gnt_idx;
      ret_pipe[2]       <= ret_pipe[1];

      // Burst count and fairness pointer are frozen across the refresh slot.
      if (!ref_slot) begin
        if (gnt[REQ_VIDEO]) begin
          if (vid_cnt != CW'(VID_BURST_MAX)) vid_cnt <= vid_cnt + 1'b1;
        end else if (gnt_any) begin
          vid_cnt <= '0;
          rr_ptr  <= (gnt_idx == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else if (!req[REQ_VIDEO]) begin
          vid_cnt <= '0;
        end
      end
    end
  end

  assign sdram_addr = cmd_q.addr;
  assign sdram_din  = cmd_q.din;
  assign sdram_ds   = cmd_q.ds;
  assign sdram_we   = cmd_vld & cmd_q.we;
  assign sdram_oe   = cmd_vld & ~cmd_q.we;
  assign rdata      = sdram_out;

  always_comb begin
    rvalid = '0;
    if (ret_pipe[2].valid) rvalid[ret_pipe[2].idx] = 1'b1;
  end

endmodule
